fpu_wb_arb: RTL and testbench

FPU_WB_ARB -- requirements
Module: fpu_wb_arb

---
 rtl/fpu_wb_arb_if.sv | 47 ++++
 rtl/fpu_wb_arb.sv | 183 ++++++++++++++++++
 tb/tb_fpu_wb_arb.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/fpu_wb_arb_if.sv
// Purpose: bundles the three FP result sources, the issue-hold back-channel and the register-file write port.
// Latency: none, wires only.
// Backpressure: Div and Cvt use valid/ready; FMA has no ready and relies on IssueHold.
// Ports: master = execution units and register file side; slave = the arbiter.
interface fpu_wb_arb_if #(
    parameter int FLEN = 64
);
    // FMA result, no backpressure
    logic            FmaV;
    logic [4:0]      FmaRd;
    logic [1:0]      FmaFmt;
    logic [FLEN-1:0] FmaRes;
    // divide/sqrt result, valid/ready
    logic            DivV;
    logic [4:0]      DivRd;
    logic [1:0]      DivFmt;
    logic [FLEN-1:0] DivRes;
    logic            DivRdy;
    // convert/move result, valid/ready
    logic            CvtV;
    logic [4:0]      CvtRd;
    logic [1:0]      CvtFmt;
    logic [FLEN-1:0] CvtRes;
    logic            CvtRdy;
    // issue stall, sticky protocol error, register-file write port
    logic            IssueHold;
    logic            FmaDropErr;
    logic            WbV;
    logic [4:0]      WbRd;
    logic [FLEN-1:0] WbData;

    modport master (
        output FmaV, FmaRd, FmaFmt, FmaRes,
        output DivV, DivRd, DivFmt, DivRes,
        output CvtV, CvtRd, CvtFmt, CvtRes,
        input  DivRdy, CvtRdy, IssueHold, FmaDropErr,
        input  WbV, WbRd, WbData
    );

    modport slave (
        input  FmaV, FmaRd, FmaFmt, FmaRes,
        input  DivV, DivRd, DivFmt, DivRes,
        input  CvtV, CvtRd, CvtFmt, CvtRes,
        output DivRdy, CvtRdy, IssueHold, FmaDropErr,
        output WbV, WbRd, WbData
    );
endinterface

// File: rtl/fpu_wb_arb.sv
// Purpose: FP register-file writeback arbiter (FMA > Div/Cvt round-robin) with an anti-starvation drain sequence.
// Latency: 1 cycle from acceptance to WbV/WbRd/WbData (NaN-boxed by format).
// Backpressure: DivRdy/CvtRdy are combinational; FMA is never stalled here, only via IssueHold.
// Ports: clk, reset_n (async active-low) and bus (fpu_wb_arb_if.slave) carrying all sources and the write port.
module fpu_wb_arb #(
    parameter int FLEN    = 64,
    parameter int FMALAT  = 4,
    parameter int MAXWAIT = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    fpu_wb_arb_if.slave bus
);

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        DRAIN  = 2'd1,
        SERVE  = 2'd2
    } state_e;

    localparam logic [7:0]      WAIT_MAX   = 8'(MAXWAIT);
    localparam logic [3:0]      DRAIN_INIT = 4'(FMALAT);
    // upper-bit masks for NaN-boxing single and half results
    localparam logic [FLEN-1:0] BOX_S      = {FLEN{1'b1}} << 32;
    localparam logic [FLEN-1:0] BOX_H      = {FLEN{1'b1}} << 16;

    state_e          state_q, state_d;
    logic [7:0]      wait_cnt_q, wait_cnt_d;
    logic [3:0]      drain_cnt_q, drain_cnt_d;
    logic            ptr_q, ptr_d;          // 0: favour Div, 1: favour Cvt
    logic            wb_v_q, wb_v_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [FLEN-1:0] wb_data_q, wb_data_d;
    logic            issue_hold_q, issue_hold_d;
    logic            drop_err_q, drop_err_d;

    logic            any_dc;
    logic            div_win, cvt_win;
    logic            fma_acc, dc_open;
    logic            div_xfer, cvt_xfer, dc_xfer, accept;
    logic [4:0]      sel_rd;
    logic [1:0]      sel_fmt;
    logic [FLEN-1:0] sel_res, boxed;

    assign any_dc  = bus.DivV | bus.CvtV;
    assign div_win = bus.DivV & (~bus.CvtV | ~ptr_q);
    assign cvt_win = bus.CvtV & (~bus.DivV |  ptr_q);

    // Who may be accepted this cycle. In DRAIN only the FMA pipe empties;
    // Div/Cvt are held back so the starved one gets the dedicated SERVE slot.
    always_comb begin
        fma_acc = 1'b0;
        dc_open = 1'b0;
        case (state_q)
            NORMAL: begin
                fma_acc = bus.FmaV;
                dc_open = ~bus.FmaV;
            end
            DRAIN:   fma_acc = bus.FmaV;
            SERVE:   dc_open = 1'b1;   // FMA result in SERVE is dropped
            default: ;
        endcase
    end

    assign div_xfer = dc_open & div_win;
    assign cvt_xfer = dc_open & cvt_win;
    assign dc_xfer  = div_xfer | cvt_xfer;
    assign accept   = fma_acc | dc_xfer;

    assign bus.DivRdy = div_xfer;
    assign bus.CvtRdy = cvt_xfer;

    always_comb begin
        sel_rd  = bus.FmaRd;
        sel_fmt = bus.FmaFmt;
        sel_res = bus.FmaRes;
        if (div_xfer) begin
            sel_rd  = bus.DivRd;
            sel_fmt = bus.DivFmt;
            sel_res = bus.DivRes;
        end else if (cvt_xfer) begin
            sel_rd  = bus.CvtRd;
            sel_fmt = bus.CvtFmt;
            sel_res = bus.CvtRes;
        end
    end

    always_comb begin
        boxed = sel_res;
        case (sel_fmt)
            2'b00:   boxed = sel_res | BOX_S;
            2'b10:   boxed = sel_res | BOX_H;
            default: boxed = sel_res;
        endcase
    end

    always_comb begin
        // The counter only means something while a Div/Cvt is waiting, so it
        // also clears when none is pending (covers abandoned drain sequences).
        wait_cnt_d = wait_cnt_q;
        if (dc_xfer || !any_dc) begin
            wait_cnt_d = 8'd0;
        end else if (wait_cnt_q < WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end

        ptr_d = ptr_q;
        if (div_xfer) begin
            ptr_d = 1'b1;
        end else if (cvt_xfer) begin
            ptr_d = 1'b0;
        end

        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            NORMAL: begin
                // wait_cnt_d is zero on any Div/Cvt transfer, so this only
                // fires for a requester still being starved.
                if (wait_cnt_d == WAIT_MAX) begin
                    state_d     = DRAIN;
                    drain_cnt_d = DRAIN_INIT;
                end
            end
            DRAIN: begin
                if (!any_dc) begin
                    state_d = NORMAL;
                end else begin
                    if (drain_cnt_q != 4'd0) begin
                        drain_cnt_d = drain_cnt_q - 4'd1;
                    end
                    if (drain_cnt_q == 4'd0 && !bus.FmaV) begin
                        state_d = SERVE;
                    end
                end
            end
            SERVE: begin
                if (dc_xfer || !any_dc) begin
                    state_d = NORMAL;
                end
            end
            default: state_d = NORMAL;
        endcase

        issue_hold_d = (state_d != NORMAL);
        drop_err_d   = drop_err_q | ((state_q == SERVE) & bus.FmaV);

        wb_v_d    = accept;
        wb_rd_d   = accept ? sel_rd : wb_rd_q;
        wb_data_d = accept ? boxed  : wb_data_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= NORMAL;
            wait_cnt_q   <= 8'd0;
            drain_cnt_q  <= 4'd0;
            ptr_q        <= 1'b0;
            wb_v_q       <= 1'b0;
            wb_rd_q      <= 5'd0;
            wb_data_q    <= '0;
            issue_hold_q <= 1'b0;
            drop_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
            ptr_q        <= ptr_d;
            wb_v_q       <= wb_v_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            issue_hold_q <= issue_hold_d;
            drop_err_q   <= drop_err_d;
        end
    end

    assign bus.WbV        = wb_v_q;
    assign bus.WbRd       = wb_rd_q;
    assign bus.WbData     = wb_data_q;
    assign bus.IssueHold  = issue_hold_q;
    assign bus.FmaDropErr = drop_err_q;

endmodule

// File: tb/tb_fpu_wb_arb.sv
// Purpose: directed self-checking bench for fpu_wb_arb (FLEN=64, FMALAT=4, MAXWAIT=8).
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled before the next edge.
// Backpressure: bench holds Div/Cvt valid until the corresponding ready is seen.
module tb_fpu_wb_arb;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_errors;
    int   n;

    fpu_wb_arb_if #(.FLEN(64)) bus ();

    fpu_wb_arb #(
        .FLEN   (64),
        .FMALAT (4),
        .MAXWAIT(8)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.FmaV = 1'b0;
        bus.DivV = 1'b0;
        bus.CvtV = 1'b0;
    endtask

    // edges until IssueHold rises, bounded
    task automatic wait_hold(output int cnt);
        cnt = 0;
        while (bus.IssueHold !== 1'b1 && cnt < 20) begin
            tick();
            cnt++;
        end
    endtask

    // edges until a Div or Cvt ready appears, bounded
    task automatic wait_srv(output int cnt);
        cnt = 0;
        #1;
        while (bus.DivRdy !== 1'b1 && bus.CvtRdy !== 1'b1 && cnt < 20) begin
            tick();
            cnt++;
            #1;
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle();
        bus.FmaRd = 5'd0; bus.FmaFmt = 2'b01; bus.FmaRes = 64'h0;
        bus.DivRd = 5'd0; bus.DivFmt = 2'b01; bus.DivRes = 64'h0;
        bus.CvtRd = 5'd0; bus.CvtFmt = 2'b01; bus.CvtRes = 64'h0;
        reset_n = 1'b0;

        // reset state
        tick();
        check("rst_wbv",   64'(bus.WbV), 64'd0);
        check("rst_wbrd",  64'(bus.WbRd), 64'd0);
        check("rst_wbdat", bus.WbData, 64'd0);
        check("rst_hold",  64'(bus.IssueHold), 64'd0);
        check("rst_err",   64'(bus.FmaDropErr), 64'd0);
        check("rst_rdy",   64'({bus.DivRdy, bus.CvtRdy}), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // round robin from reset pointer: Div, Cvt, Div, Cvt
        bus.DivV = 1'b1; bus.DivRd = 5'd1; bus.DivFmt = 2'b01; bus.DivRes = 64'hD;
        bus.CvtV = 1'b1; bus.CvtRd = 5'd2; bus.CvtFmt = 2'b01; bus.CvtRes = 64'hC;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_divrdy", 64'(bus.DivRdy), (i % 2 == 0) ? 64'd1 : 64'd0);
            check("rr_cvtrdy", 64'(bus.CvtRdy), (i % 2 == 0) ? 64'd0 : 64'd1);
            tick();
            if (i == 3) idle();
            check("rr_wbrd", 64'(bus.WbRd), (i % 2 == 0) ? 64'd1 : 64'd2);
        end

        // single Div, NaN-boxed single
        bus.DivV = 1'b1; bus.DivRd = 5'd5; bus.DivFmt = 2'b00; bus.DivRes = 64'h0000_0000_3F80_0000;
        #1;
        check("div_rdy", 64'(bus.DivRdy), 64'd1);
        check("div_cvtrdy", 64'(bus.CvtRdy), 64'd0);
        tick();
        idle();
        check("div_wbv",  64'(bus.WbV), 64'd1);
        check("div_wbrd", 64'(bus.WbRd), 64'd5);
        check("div_wbdat", bus.WbData, 64'hFFFF_FFFF_3F80_0000);
        tick();
        check("idle_wbv", 64'(bus.WbV), 64'd0);

        // all three valid in NORMAL: FMA wins
        bus.FmaV = 1'b1; bus.FmaRd = 5'd7; bus.FmaFmt = 2'b00; bus.FmaRes = 64'hAAAA_BBBB_4049_0FDB;
        bus.DivV = 1'b1; bus.CvtV = 1'b1;
        #1;
        check("all3_rdy", 64'({bus.DivRdy, bus.CvtRdy}), 64'd0);
        tick();
        idle();
        check("all3_wbrd",  64'(bus.WbRd), 64'd7);
        check("all3_wbdat", bus.WbData, 64'hFFFF_FFFF_4049_0FDB);

        // NaN-boxing: half, and pass-through for 01 and 11, back to back
        bus.FmaV = 1'b1; bus.FmaRd = 5'd8; bus.FmaFmt = 2'b10; bus.FmaRes = 64'h1234_5678_9ABC_3C00;
        tick();
        check("box_h", bus.WbData, 64'hFFFF_FFFF_FFFF_3C00);
        bus.FmaRd = 5'd9; bus.FmaFmt = 2'b01; bus.FmaRes = 64'h0123_4567_89AB_CDEF;
        tick();
        check("box_01", bus.WbData, 64'h0123_4567_89AB_CDEF);
        bus.FmaRd = 5'd10; bus.FmaFmt = 2'b11; bus.FmaRes = 64'hFEDC_BA98_7654_3210;
        tick();
        idle();
        check("box_11", bus.WbData, 64'hFEDC_BA98_7654_3210);
        check("box_11_rd", 64'(bus.WbRd), 64'd10);
        tick();
        check("box_end_wbv", 64'(bus.WbV), 64'd0);

        // starvation: FMA stream blocks Div, drain, serve
        bus.FmaV = 1'b1; bus.FmaFmt = 2'b01;
        bus.DivV = 1'b1; bus.DivRd = 5'd9; bus.DivFmt = 2'b01; bus.DivRes = 64'h4000_0000_0000_0000;
        wait_hold(n);
        check("starve_hold_cyc", 64'(n), 64'd8);
        bus.FmaV = 1'b0;
        wait_srv(n);
        check("starve_drain_cyc", 64'(n), 64'd5);
        check("starve_cvtrdy", 64'(bus.CvtRdy), 64'd0);
        check("starve_hold_srv", 64'(bus.IssueHold), 64'd1);
        tick();
        idle();
        check("starve_wbrd", 64'(bus.WbRd), 64'd9);
        check("starve_wbdat", bus.WbData, 64'h4000_0000_0000_0000);
        check("starve_hold_fall", 64'(bus.IssueHold), 64'd0);

        // FMA result presented in SERVE is dropped and flagged
        bus.FmaV = 1'b1; bus.FmaRd = 5'd20;
        bus.CvtV = 1'b1; bus.CvtRd = 5'd3; bus.CvtFmt = 2'b01; bus.CvtRes = 64'h55;
        wait_hold(n);
        check("drop_hold_cyc", 64'(n), 64'd8);
        bus.FmaV = 1'b0;
        wait_srv(n);
        check("drop_drain_cyc", 64'(n), 64'd5);
        bus.FmaV = 1'b1;
        #1;
        check("drop_cvtrdy", 64'(bus.CvtRdy), 64'd1);
        tick();
        idle();
        check("drop_wbrd", 64'(bus.WbRd), 64'd3);
        check("drop_wbdat", bus.WbData, 64'h55);
        check("drop_err", 64'(bus.FmaDropErr), 64'd1);
        tick();
        check("drop_no_fma_wb", 64'(bus.WbV), 64'd0);
        check("drop_err_sticky", 64'(bus.FmaDropErr), 64'd1);

        // requesters withdraw during DRAIN: back to NORMAL
        bus.FmaV = 1'b1; bus.DivV = 1'b1; bus.DivRd = 5'd12;
        wait_hold(n);
        check("wd_hold_cyc", 64'(n), 64'd8);
        idle();
        tick();
        check("wd_hold_low", 64'(bus.IssueHold), 64'd0);
        bus.DivV = 1'b1;
        #1;
        check("wd_divrdy", 64'(bus.DivRdy), 64'd1);
        tick();
        idle();
        check("wd_wbrd", 64'(bus.WbRd), 64'd12);

        // reset pulse during DRAIN
        bus.FmaV = 1'b1; bus.DivV = 1'b1;
        wait_hold(n);
        check("rd_hold_cyc", 64'(n), 64'd8);
        #1;
        reset_n = 1'b0;
        #1;
        check("rd_hold_clr", 64'(bus.IssueHold), 64'd0);
        check("rd_err_clr",  64'(bus.FmaDropErr), 64'd0);
        check("rd_wbv_clr",  64'(bus.WbV), 64'd0);
        idle();
        tick();
        reset_n = 1'b1;
        tick();
        check("rd_no_replay", 64'(bus.WbV), 64'd0);
        bus.FmaV = 1'b1; bus.FmaRd = 5'd11; bus.FmaFmt = 2'b01; bus.FmaRes = 64'h77;
        tick();
        check("rd_fma_wbv",  64'(bus.WbV), 64'd1);
        check("rd_fma_wbrd", 64'(bus.WbRd), 64'd11);
        bus.DivV = 1'b1;
        wait_hold(n);
        check("rd_wait_from0", 64'(n), 64'd8);
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
